uart_frame_dec: RTL and testbench

Byte-level frame decoder sitting directly downstream of the serial receiver. Consumes the receiver's one-cycle byte strobe and data. Hunts for a header byte, collects address, length, payload and checksum, and buffers the payload internally. Releases the payload as a burst only when the checksum passes; otherwise it flags an error and discards the frame.

---
 rtl/uart_frame_dec.sv | 194 +++++++++++++++++++
 tb/tb_uart_frame_dec.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_dec.sv
// Byte-level frame decoder: HEADER, ADDR, LEN, payload, CHK -> payload burst on a good checksum.
// Optional inter-byte timeout is built when FRAME_TIMEOUT_EN is defined.
module uart_frame_dec #(
    parameter int         UART_BPS = 9600,
    parameter int         CLK_FREQ = 50_000_000,
    parameter int         MAX_LEN  = 16,
    parameter logic [7:0] HEADER   = 8'hAA
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       pi_flag,
    input  logic [7:0] pi_data,
    output logic       po_flag,
    output logic [7:0] po_data,
    output logic       po_sop,
    output logic       po_eop,
    output logic [7:0] po_addr,
    output logic       err_flag,
    output logic [1:0] err_code
);

    localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    // IDLE: hunt header | ADDR/LEN/DATA/CHK: collect frame | DRAIN: burst buffered payload
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t        r_state;
    logic [7:0]    r_addr;
    logic [7:0]    r_len;
    logic [7:0]    r_chk;
    logic [IW-1:0] r_wr_idx;
    logic [IW-1:0] r_rd_idx;
    logic          r_hold_vld;
    logic [7:0]    r_hold_data;
    logic [7:0]    r_buf [MAX_LEN];

    logic          w_vld;
    logic [7:0]    w_byte;
    logic          w_timeout;

    // A byte parked during DRAIN takes priority once the burst has finished.
    assign w_vld  = (r_state != S_DRAIN) && (r_hold_vld || pi_flag);
    assign w_byte = r_hold_vld ? r_hold_data : pi_data;

`ifdef FRAME_TIMEOUT_EN
    localparam int TO_CNT = 20 * (CLK_FREQ / UART_BPS);
    localparam int TW     = $clog2(TO_CNT + 1);

    logic [TW-1:0] r_to_cnt;
    logic          w_active;

    assign w_active  = (r_state == S_ADDR) || (r_state == S_LEN) ||
                       (r_state == S_DATA) || (r_state == S_CHK);
    assign w_timeout = w_active && !w_vld && (r_to_cnt == TW'(TO_CNT - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_to_cnt <= '0;
        end else if (!w_active || w_vld || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end
`else
    logic [31:0] w_unused_rate;

    assign w_unused_rate = 32'(CLK_FREQ / UART_BPS);
    assign w_timeout     = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (r_state == S_DATA && w_vld) begin
            r_buf[r_wr_idx] <= w_byte;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_chk       <= '0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
            po_flag     <= 1'b0;
            po_data     <= '0;
            po_sop      <= 1'b0;
            po_eop      <= 1'b0;
            po_addr     <= '0;
            err_flag    <= 1'b0;
            err_code    <= '0;
        end else begin
            po_flag  <= 1'b0;
            po_sop   <= 1'b0;
            po_eop   <= 1'b0;
            err_flag <= 1'b0;

            if (r_state == S_DRAIN) begin
                if (pi_flag) begin
                    r_hold_vld  <= 1'b1;
                    r_hold_data <= pi_data;
                end
            end else if (r_hold_vld) begin
                r_hold_vld  <= pi_flag;
                r_hold_data <= pi_data;
            end

            if (w_timeout) begin
                err_flag <= 1'b1;
                err_code <= 2'd3;
                r_state  <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_vld && w_byte == HEADER) begin
                            r_chk   <= '0;
                            r_state <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        if (w_vld) begin
                            r_addr  <= w_byte;
                            r_chk   <= r_chk + w_byte;
                            r_state <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (w_vld) begin
                            if (w_byte == 8'd0 || w_byte > MAX_LEN_B) begin
                                err_flag <= 1'b1;
                                err_code <= 2'd1;
                                r_state  <= S_IDLE;
                            end else begin
                                r_len    <= w_byte;
                                r_wr_idx <= '0;
                                r_chk    <= r_chk + w_byte;
                                r_state  <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_vld) begin
                            r_chk    <= r_chk + w_byte;
                            r_wr_idx <= r_wr_idx + IW'(1);
                            if (8'(r_wr_idx) == r_len - 8'd1) begin
                                r_state <= S_CHK;
                            end
                        end
                    end
                    S_CHK: begin
                        if (w_vld) begin
                            if (w_byte == r_chk) begin
                                // First payload byte goes out on the same edge that accepts CHK.
                                po_addr  <= r_addr;
                                po_flag  <= 1'b1;
                                po_data  <= r_buf[0];
                                po_sop   <= 1'b1;
                                po_eop   <= (r_len == 8'd1);
                                r_rd_idx <= IW'(1);
                                r_state  <= (r_len == 8'd1) ? S_IDLE : S_DRAIN;
                            end else begin
                                err_flag <= 1'b1;
                                err_code <= 2'd2;
                                r_state  <= S_IDLE;
                            end
                        end
                    end
                    S_DRAIN: begin
                        po_flag  <= 1'b1;
                        po_data  <= r_buf[r_rd_idx];
                        r_rd_idx <= r_rd_idx + IW'(1);
                        if (8'(r_rd_idx) == r_len - 8'd1) begin
                            po_eop  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_dec.sv
// Randomized bench for uart_frame_dec against a queue-based frame parser model.
// Exercises the timeout path as well when FRAME_TIMEOUT_EN is defined.
module tb_uart_frame_dec;

    localparam int         CLK_FREQ = 1_000_000;
    localparam int         UART_BPS = 50_000;
    localparam int         MAX_LEN  = 16;
    localparam logic [7:0] HDR      = 8'hAA;
    localparam int         TO_CNT   = 20 * (CLK_FREQ / UART_BPS);
    localparam int         GAP      = 20;

    logic       sys_clk;
    logic       sys_rst;
    logic       pi_flag;
    logic [7:0] pi_data;
    logic       po_flag;
    logic [7:0] po_data;
    logic       po_sop;
    logic       po_eop;
    logic [7:0] po_addr;
    logic       err_flag;
    logic [1:0] err_code;

    uart_frame_dec #(
        .UART_BPS(UART_BPS),
        .CLK_FREQ(CLK_FREQ),
        .MAX_LEN (MAX_LEN),
        .HEADER  (HDR)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .pi_flag (pi_flag),
        .pi_data (pi_data),
        .po_flag (po_flag),
        .po_data (po_data),
        .po_sop  (po_sop),
        .po_eop  (po_eop),
        .po_addr (po_addr),
        .err_flag(err_flag),
        .err_code(err_code)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        bit         sop;
        bit         eop;
        logic [7:0] addr;
        logic [1:0] code;
        int         cyc;
    } ev_t;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] frm[$];
    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [7:0] last_addr = 8'h00;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_err(input logic [1:0] code, input int at);
        ev_t e;
        e.is_err = 1'b1; e.data = '0; e.sop = 1'b0; e.eop = 1'b0;
        e.addr = '0; e.code = code; e.cyc = at;
        exp_q.push_back(e);
    endtask

    // Frame parser: collects bytes after a header and judges the frame once it is complete.
    task automatic model_byte(input logic [7:0] b, input int n);
        int   sum;
        int   len;
        ev_t  e;
        if (frm.size() == 0) begin
            if (b == HDR) frm.push_back(b);
            return;
        end
        frm.push_back(b);
        if (frm.size() == 3 && (b == 8'd0 || int'(b) > MAX_LEN)) begin
            push_err(2'd1, n + 1);
            frm.delete();
        end else if (frm.size() >= 4 && frm.size() == 4 + int'(frm[2])) begin
            len = int'(frm[2]);
            sum = 0;
            for (int i = 1; i < frm.size() - 1; i++) sum += int'(frm[i]);
            if (8'(sum) == b) begin
                last_addr = frm[1];
                for (int k = 0; k < len; k++) begin
                    e.is_err = 1'b0; e.data = frm[3 + k]; e.sop = (k == 0);
                    e.eop = (k == len - 1); e.addr = frm[1]; e.code = '0; e.cyc = n + 1 + k;
                    exp_q.push_back(e);
                end
            end else begin
                push_err(2'd2, n + 1);
            end
            frm.delete();
        end
    endtask

    // Called on a falling edge; returns gap cycles later, again on a falling edge.
    task automatic send(input logic [7:0] b, input int gap);
        pi_flag = 1'b1;
        pi_data = b;
        model_byte(b, cyc);
        @(negedge sys_clk);
        pi_flag = 1'b0;
        pi_data = 8'($urandom);
        repeat (gap - 1) @(negedge sys_clk);
    endtask

    task automatic send_q(input logic [7:0] bq[$], input int gap);
        foreach (bq[i]) send(bq[i], gap);
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [7:0] pl[$],
                              input logic [7:0] chk_xor, input int last_gap);
        logic [7:0] c;
        c = addr + 8'(pl.size());
        foreach (pl[i]) c = c + pl[i];
        send(HDR, GAP);
        send(addr, GAP);
        send(8'(pl.size()), GAP);
        foreach (pl[i]) send(pl[i], GAP);
        send(c ^ chk_xor, last_gap);
    endtask

    task automatic settle();
        repeat (40) @(negedge sys_clk);
        chk("pending_events", exp_q.size(), 0);
    endtask

    always @(negedge sys_clk) begin
        if (!sys_rst && (po_flag || err_flag)) begin
            chk("po_err_exclusive", {31'b0, po_flag & err_flag}, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_output", po_flag ? 32'd1 : 32'd2, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_kind", {31'b0, err_flag}, {31'b0, mon_e.is_err});
                chk("event_cycle", cyc, mon_e.cyc);
                if (po_flag) begin
                    chk("po_data", po_data, mon_e.data);
                    chk("po_sop", {31'b0, po_sop}, {31'b0, mon_e.sop});
                    chk("po_eop", {31'b0, po_eop}, {31'b0, mon_e.eop});
                    chk("po_addr", po_addr, mon_e.addr);
                end else begin
                    chk("err_code", err_code, mon_e.code);
                end
            end
        end
    end

    initial begin
        logic [7:0] bq[$];
        logic [7:0] pl[$];
        int         len;
        int         r;
        int         last_gap;
        bit         short_prev;

        sys_rst = 1'b1;
        pi_flag = 1'b0;
        pi_data = 8'h00;
        repeat (3) @(negedge sys_clk);
        chk("rst_po_flag", {31'b0, po_flag}, 0);
        chk("rst_po_data", po_data, 0);
        chk("rst_po_sop", {31'b0, po_sop}, 0);
        chk("rst_po_eop", {31'b0, po_eop}, 0);
        chk("rst_po_addr", po_addr, 0);
        chk("rst_err_flag", {31'b0, err_flag}, 0);
        chk("rst_err_code", err_code, 0);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        // good frame, then bad checksum, then good again
        bq = {HDR, 8'h05, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6E};
        send_q(bq, GAP);
        settle();
        chk("addr_after_good", po_addr, 8'h05);
        bq = {HDR, 8'h05, 8'h03, 8'h11, 8'h22, 8'h33, 8'h70};
        send_q(bq, GAP);
        settle();
        chk("code_holds_2", err_code, 2);
        chk("addr_holds_bad_chk", po_addr, last_addr);
        bq = {HDR, 8'h09, 8'h02, 8'hAA, 8'h00, 8'hB5};
        send_q(bq, GAP);
        settle();

        // bad lengths, trailing bytes ignored
        bq = {HDR, 8'h01, 8'h00, 8'h33, 8'h44, HDR, 8'h01, 8'h11, 8'h55, 8'h66};
        send_q(bq, GAP);
        settle();
        chk("code_holds_1", err_code, 1);
        chk("addr_holds_bad_len", po_addr, 8'h09);

        // noise, header as address, then single-byte payload
        bq = {8'h00, 8'hFF, HDR, HDR, 8'h01, HDR, 8'hAC};
        send_q(bq, GAP);
        settle();
        bq = {HDR, HDR, 8'h01, HDR, 8'h55};
        send_q(bq, GAP);
        settle();
        chk("addr_header_value", po_addr, 8'hAA);

        // back-to-back full-length frames, next header lands inside DRAIN
        for (int f = 0; f < 4; f++) begin
            pl.delete();
            for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'($urandom));
            send_frame(8'($urandom), pl, 8'h00, 2 + f);
        end
        repeat (GAP) @(negedge sys_clk);
        settle();

        // randomized frames
        short_prev = 1'b0;
        for (int f = 0; f < 40; f++) begin
            if (!short_prev) begin
                r = $urandom_range(0, 2);
                for (int i = 0; i < r; i++) begin
                    pi_data = 8'($urandom_range(0, 254));
                    send((pi_data == HDR) ? 8'h00 : pi_data, $urandom_range(GAP - 2, GAP + 8));
                end
            end
            r = $urandom_range(0, 9);
            if (r == 0) len = 0;
            else if (r == 1) len = $urandom_range(MAX_LEN + 1, 255);
            else len = $urandom_range(1, MAX_LEN);
            if (len == 0 || len > MAX_LEN) begin
                send(HDR, GAP);
                send(8'($urandom), GAP);
                send(8'(len), GAP);
                short_prev = 1'b0;
            end else begin
                pl.delete();
                for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
                short_prev = ($urandom_range(0, 1) == 1);
                last_gap = short_prev ? $urandom_range(1, len + 1) : $urandom_range(GAP - 2, GAP + 10);
                send_frame(8'($urandom), pl,
                           ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                           last_gap);
            end
        end
        repeat (GAP) @(negedge sys_clk);
        settle();

        // reset in the middle of a payload
        bq = {HDR, 8'h07, 8'h04, 8'h01, 8'h02};
        send_q(bq, GAP);
        chk("pending_before_rst", exp_q.size(), 0);
        #3 sys_rst = 1'b1;
        #1;
        chk("midrst_po_flag", {31'b0, po_flag}, 0);
        chk("midrst_po_data", po_data, 0);
        chk("midrst_po_addr", po_addr, 0);
        chk("midrst_err_flag", {31'b0, err_flag}, 0);
        chk("midrst_err_code", err_code, 0);
        frm.delete();
        last_addr = 8'h00;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        pl = {8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(8'h07, pl, 8'h00, GAP);
        settle();
        chk("addr_after_rst_frame", po_addr, 8'h07);

        // truncated frame: times out when enabled, otherwise resumes
        send(HDR, GAP);
        send(8'h05, GAP);
        send(8'h02, GAP);
        pi_flag = 1'b1;
        pi_data = 8'h11;
        model_byte(8'h11, cyc);
`ifdef FRAME_TIMEOUT_EN
        push_err(2'd3, cyc + 1 + TO_CNT);
        frm.delete();
`endif
        @(negedge sys_clk);
        pi_flag = 1'b0;
        repeat (TO_CNT + 50) @(negedge sys_clk);
`ifdef FRAME_TIMEOUT_EN
        chk("code_holds_3", err_code, 3);
`endif
        bq = {8'h22, 8'h3A};
        send_q(bq, GAP);
        settle();
        pl = {8'h5A, HDR, 8'hC3};
        send_frame(8'h42, pl, 8'h00, GAP);
        settle();
        chk("addr_final", po_addr, last_addr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
